// File: rtl/binary_byte_printer.sv
// Prints one byte as eight ASCII '0'/'1' characters (optionally followed by CR LF)
// through the UART transmit handshake, one character per tx_busy-free slot.
module binary_byte_printer #(
   parameter bit MSB_FIRST = 1'b1,
   parameter bit NEWLINE   = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] data_in,
   input  logic       new_data_in,
   output logic       busy,
   output logic       dropped,
   output logic [7:0] tx_data,
   output logic       new_tx_data,
   input  logic       tx_busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      GAP  = 2'd2
   } state_t;

   localparam logic [3:0] LAST_IDX = NEWLINE ? 4'd9 : 4'd7;

   state_t     state, state_nx;
   logic [3:0] idx, idx_nx;
   logic [7:0] shadow, shadow_nx;
   logic [7:0] tx_data_nx;
   logic       new_tx_data_nx;
   logic       dropped_nx;

   // Index 0..7 selects a digit, 8 and 9 are the CR LF trailer.
   function automatic logic [7:0] char_at(input logic [7:0] s, input logic [3:0] i);
      logic b;
      if (i == 4'd8) begin
         char_at = 8'h0D;
      end else if (i == 4'd9) begin
         char_at = 8'h0A;
      end else begin
         b = MSB_FIRST ? s[~i[2:0]] : s[i[2:0]];
         char_at = {7'b0011000, b};
      end
   endfunction

   always_comb begin
      state_nx       = state;
      idx_nx         = idx;
      shadow_nx      = shadow;
      tx_data_nx     = tx_data;
      new_tx_data_nx = 1'b0;
      dropped_nx     = new_data_in && (state != IDLE);
      case (state)
         IDLE: begin
            if (new_data_in) begin
               shadow_nx = data_in;
               idx_nx    = 4'd0;
               state_nx  = SEND;
            end
         end
         SEND: begin
            if (!tx_busy) begin
               new_tx_data_nx = 1'b1;
               tx_data_nx     = char_at(shadow, idx);
               if (idx == LAST_IDX) begin
                  state_nx = IDLE;
               end else begin
                  idx_nx   = idx + 4'd1;
                  state_nx = GAP;
               end
            end
         end
         // The transmitter raises tx_busy one cycle after a strobe, so skip a cycle.
         GAP: state_nx = SEND;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         idx         <= 4'd0;
         shadow      <= 8'h00;
         tx_data     <= 8'h00;
         new_tx_data <= 1'b0;
         busy        <= 1'b0;
         dropped     <= 1'b0;
      end else begin
         state       <= state_nx;
         idx         <= idx_nx;
         shadow      <= shadow_nx;
         tx_data     <= tx_data_nx;
         new_tx_data <= new_tx_data_nx;
         busy        <= (state_nx != IDLE);
         dropped     <= dropped_nx;
      end
   end

endmodule

// File: tb/tb_binary_byte_printer.sv
// Bench for binary_byte_printer: default instance (MSB first, CR LF) plus an
// LSB-first, digits-only instance, both checked against a string-building model.
module tb_binary_byte_printer;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] data_in = 8'h00;
   logic       new_data_in = 1'b0;
   logic       busy, dropped, new_tx_data;
   logic [7:0] tx_data;
   logic       tx_busy = 1'b0;

   logic [7:0] data_in2 = 8'h00;
   logic       new_data_in2 = 1'b0;
   logic       busy2, dropped2, new_tx_data2;
   logic [7:0] tx_data2;
   logic       tx_busy2 = 1'b0;

   int n_chk = 0;
   int n_fail = 0;
   logic [7:0] exp_q[$];

   always #5 clk = ~clk;

   binary_byte_printer dut (
      .clk(clk), .rst(rst), .data_in(data_in), .new_data_in(new_data_in),
      .busy(busy), .dropped(dropped), .tx_data(tx_data),
      .new_tx_data(new_tx_data), .tx_busy(tx_busy)
   );

   binary_byte_printer #(.MSB_FIRST(1'b0), .NEWLINE(1'b0)) dut2 (
      .clk(clk), .rst(rst), .data_in(data_in2), .new_data_in(new_data_in2),
      .busy(busy2), .dropped(dropped2), .tx_data(tx_data2),
      .new_tx_data(new_tx_data2), .tx_busy(tx_busy2)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Expected message text: "0"/"1" digits in the chosen order, then optional "\r\n".
   task automatic build(input logic [7:0] v, input bit msb, input bit nl);
      int pos;
      exp_q.delete();
      for (int i = 0; i < 8; i++) begin
         pos = msb ? (7 - i) : i;
         exp_q.push_back(8'(48 + ((int'(v) >> pos) % 2)));
      end
      if (nl) begin
         exp_q.push_back(8'd13);
         exp_q.push_back(8'd10);
      end
   endtask

   task automatic start(input logic [7:0] v);
      data_in = v;
      new_data_in = 1'b1;
   endtask

   // Strobe must already be driven in the current cycle; tx_busy is low throughout.
   task automatic run_msg(input logic [7:0] v, input int drop_at, input bit chain,
                          input logic [7:0] chain_v);
      build(v, 1'b1, 1'b1);
      for (int k = 1; k <= 20; k++) begin
         tick();
         new_data_in = 1'b0;
         data_in = 8'($urandom);
         n_chk++;
         if (busy !== (k < 20)) begin
            n_fail++;
            $display("FAIL busy v=%h k=%0d got=%b exp=%b", v, k, busy, (k < 20));
         end
         n_chk++;
         if (k % 2 == 0) begin
            if (new_tx_data !== 1'b1 || tx_data !== exp_q[k/2-1]) begin
               n_fail++;
               $display("FAIL char v=%h k=%0d got strobe=%b data=%h exp data=%h",
                        v, k, new_tx_data, tx_data, exp_q[k/2-1]);
            end
         end else if (new_tx_data !== 1'b0) begin
            n_fail++;
            $display("FAIL gap_strobe v=%h k=%0d got=%b exp=0", v, k, new_tx_data);
         end
         n_chk++;
         if (dropped !== (k == drop_at + 1 && drop_at > 0)) begin
            n_fail++;
            $display("FAIL dropped v=%h k=%0d got=%b exp=%b", v, k, dropped,
                     (k == drop_at + 1 && drop_at > 0));
         end
         if (k == drop_at) start(8'hFF);
         if (k == 20 && chain) start(chain_v);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      n_chk += 6;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got=%b exp=0", busy); end
      if (new_tx_data !== 1'b0) begin n_fail++; $display("FAIL rst_strobe got=%b exp=0", new_tx_data); end
      if (tx_data !== 8'h00) begin n_fail++; $display("FAIL rst_txdata got=%h exp=00", tx_data); end
      if (dropped !== 1'b0) begin n_fail++; $display("FAIL rst_dropped got=%b exp=0", dropped); end
      if (busy2 !== 1'b0) begin n_fail++; $display("FAIL rst_busy2 got=%b exp=0", busy2); end
      if (tx_data2 !== 8'h00) begin n_fail++; $display("FAIL rst_txdata2 got=%h exp=00", tx_data2); end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_msb_newline();
      logic [7:0] v;
      for (int n = 0; n < 4; n++) begin
         v = (n == 0) ? 8'hA5 : 8'($urandom);
         start(v);
         run_msg(v, -1, 1'b0, 8'h00);
         tick();
      end
   endtask

   task automatic test_lsb_plain();
      logic [7:0] v;
      int pulses;
      for (int n = 0; n < 3; n++) begin
         v = (n == 0) ? 8'h0F : 8'($urandom);
         build(v, 1'b0, 1'b0);
         data_in2 = v;
         new_data_in2 = 1'b1;
         pulses = 0;
         for (int k = 1; k <= 24; k++) begin
            tick();
            new_data_in2 = 1'b0;
            data_in2 = 8'($urandom);
            if (new_tx_data2) begin
               n_chk++;
               if (k % 2 != 0 || pulses >= 8 || tx_data2 !== exp_q[pulses % 8]) begin
                  n_fail++;
                  $display("FAIL lsb_char v=%h k=%0d got=%h exp=%h", v, k, tx_data2,
                           exp_q[pulses % 8]);
               end
               pulses++;
            end
         end
         n_chk += 2;
         if (pulses != 8) begin n_fail++; $display("FAIL lsb_count v=%h got=%0d exp=8", v, pulses); end
         if (busy2 !== 1'b0) begin n_fail++; $display("FAIL lsb_idle got=%b exp=0", busy2); end
      end
   endtask

   task automatic test_uart_busy();
      logic [7:0] got[$];
      int cnt, cyc;
      bit pend, prev_txb;
      build(8'h3C, 1'b1, 1'b1);
      start(8'h3C);
      cnt = 0; pend = 0; prev_txb = 0; cyc = 0;
      while (cyc < 1500 && !(got.size() >= 10 && busy === 1'b0)) begin
         tick();
         cyc++;
         new_data_in = 1'b0;
         if (pend) cnt = 50;
         pend = 0;
         if (new_tx_data) begin
            n_chk++;
            if (prev_txb !== 1'b0) begin
               n_fail++;
               $display("FAIL uart_slot cyc=%0d got tx_busy=%b exp=0", cyc, prev_txb);
            end
            got.push_back(tx_data);
            pend = 1;
         end
         tx_busy = (cnt > 0);
         if (cnt > 0) cnt--;
         prev_txb = tx_busy;
      end
      for (int k = 0; k < 120; k++) begin
         tick();
         if (new_tx_data) got.push_back(tx_data);
      end
      tx_busy = 1'b0;
      n_chk++;
      if (got.size() != 10) begin
         n_fail++;
         $display("FAIL uart_count got=%0d exp=10", got.size());
      end
      for (int i = 0; i < 10 && i < got.size(); i++) begin
         n_chk++;
         if (got[i] !== exp_q[i]) begin
            n_fail++;
            $display("FAIL uart_char i=%0d got=%h exp=%h", i, got[i], exp_q[i]);
         end
      end
   endtask

   task automatic test_drop();
      start(8'h55);
      run_msg(8'h55, 5, 1'b0, 8'h00);
      tick();
   endtask

   task automatic test_reset_mid();
      int pulses;
      pulses = 0;
      start(8'h5A);
      for (int k = 0; k < 40 && pulses < 4; k++) begin
         tick();
         new_data_in = 1'b0;
         if (new_tx_data) pulses++;
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      n_chk += 2;
      if (new_tx_data !== 1'b0) begin n_fail++; $display("FAIL midrst_strobe got=%b exp=0", new_tx_data); end
      if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy got=%b exp=0", busy); end
      pulses = 0;
      for (int k = 0; k < 30; k++) begin
         tick();
         if (new_tx_data) pulses++;
      end
      n_chk++;
      if (pulses != 0) begin n_fail++; $display("FAIL midrst_extra got=%0d exp=0", pulses); end
      // Reset and strobe together: the value must not be latched.
      start(8'h77);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      new_data_in = 1'b0;
      pulses = 0;
      for (int k = 0; k < 10; k++) begin
         tick();
         if (new_tx_data || busy) pulses++;
      end
      n_chk++;
      if (pulses != 0) begin n_fail++; $display("FAIL rst_strobe_latched got=%0d exp=0", pulses); end
      start(8'h80);
      run_msg(8'h80, -1, 1'b0, 8'h00);
      tick();
   endtask

   task automatic test_back_to_back();
      start(8'h33);
      run_msg(8'h33, -1, 1'b1, 8'h01);
      run_msg(8'h01, -1, 1'b0, 8'h00);
      tick();
   endtask

   initial begin
      test_reset();
      test_msb_newline();
      test_lsb_plain();
      test_uart_busy();
      test_drop();
      test_reset_mid();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
